// File: rtl/header_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module     : header_pkg
//  Description: Shared types and helpers for the header inserter/remover pair.
//               Provides the inserter FSM state type and the header beat
//               count helper used to size the serializer.
//  Revision   : 1.0 - initial release
// ============================================================================
package header_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } hdr_ins_state_t;

    // Number of stream beats needed to carry one header.
    function automatic int hdr_beats(input int hsize, input int dwidth);
        return hsize / dwidth;
    endfunction

endpackage
`default_nettype wire

// File: rtl/header_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module     : header_serializer
//  Description: Parallel-load shift register that presents a header one
//               DATA_WIDTH beat at a time, MSB beat first, with a beat
//               counter flagging the first and last beat.
//  Ports      : clk, rst      - clock, synchronous active-high reset
//               load, header  - capture a new header and restart the count
//               advance       - current beat consumed, move to the next one
//               data          - current header beat
//               first, last   - current beat is the first / last of header
//  Revision   : 1.0 - initial release
// ============================================================================
module header_serializer
    import header_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int HEADER_SIZE = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   advance,
    input  logic [HEADER_SIZE-1:0] header,
    output logic [DATA_WIDTH-1:0]  data,
    output logic                   first,
    output logic                   last
);

    localparam int c_BEATS = hdr_beats(HEADER_SIZE, DATA_WIDTH);
    localparam int c_CNT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;

    logic [HEADER_SIZE-1:0] r_shift;
    logic [c_CNT_W-1:0]     r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (load) begin
            r_shift <= header;
            r_cnt   <= '0;
        end else if (advance) begin
            // The count may wrap after the final beat; the owner leaves the
            // header phase on that same edge, so the wrapped value is unused.
            r_shift <= r_shift << DATA_WIDTH;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign data  = r_shift[HEADER_SIZE-1 -: DATA_WIDTH];
    assign first = (r_cnt == '0);
    assign last  = (r_cnt == c_CNT_W'(c_BEATS - 1));

endmodule
`default_nettype wire

// File: rtl/header_inserter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module     : header_inserter
//  Description: Prepends a HEADER_SIZE-bit header to every Avalon-ST packet.
//               The header arrives on a valid/ready side port, is emitted as
//               HEADER_SIZE/DATA_WIDTH beats (first beat carries sop), and the
//               payload packet then passes through unchanged with its own sop
//               suppressed.
//  Ports      : clk, rst         - clock, synchronous active-high reset
//               header_*         - header side port (valid/ready/data)
//               data_in_*        - payload stream sink (valid/ready/data/sop/eop)
//               data_out_*       - header+payload stream source
//  Revision   : 1.0 - initial release
// ============================================================================
module header_inserter
    import header_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int HEADER_SIZE = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    // payload stream in
    input  logic                   data_in_valid,
    output logic                   data_in_ready,
    input  logic [DATA_WIDTH-1:0]  data_in_data,
    input  logic                   data_in_sop,
    input  logic                   data_in_eop,
    // header side port
    input  logic [HEADER_SIZE-1:0] header_data,
    input  logic                   header_valid,
    output logic                   header_ready,
    // header + payload stream out
    output logic                   data_out_valid,
    input  logic                   data_out_ready,
    output logic [DATA_WIDTH-1:0]  data_out_data,
    output logic                   data_out_sop,
    output logic                   data_out_eop
);

    if ((HEADER_SIZE < DATA_WIDTH) || ((HEADER_SIZE % DATA_WIDTH) != 0)) begin : g_bad_header_size
        $fatal(1, "header_inserter: HEADER_SIZE must be a non-zero multiple of DATA_WIDTH");
    end

    hdr_ins_state_t          r_state;
    logic                    r_hdr_ready;
    logic                    w_hdr_fire;
    logic                    w_ser_load;
    logic                    w_ser_advance;
    logic [DATA_WIDTH-1:0]   w_ser_data;
    logic                    w_ser_first;
    logic                    w_ser_last;
    logic                    w_pay_fire;
    // Input sop carries no meaning here: the header beat owns the packet start.
    logic                    w_unused_sop;

    assign w_unused_sop  = data_in_sop;
    assign w_hdr_fire    = header_valid && r_hdr_ready;
    assign w_ser_load    = (r_state == IDLE) && w_hdr_fire;
    assign w_ser_advance = (r_state == HEADER) && data_out_ready;
    assign w_pay_fire    = (r_state == PAYLOAD) && data_in_valid && data_out_ready;

    header_serializer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .HEADER_SIZE (HEADER_SIZE)
    ) u_serializer (
        .clk     (clk),
        .rst     (rst),
        .load    (w_ser_load),
        .advance (w_ser_advance),
        .header  (header_data),
        .data    (w_ser_data),
        .first   (w_ser_first),
        .last    (w_ser_last)
    );

    // header_ready is registered so it stays low throughout reset and only
    // rises on the first cycle spent in IDLE after reset or after a packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_hdr_ready <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hdr_fire) begin
                        r_state     <= HEADER;
                        r_hdr_ready <= 1'b0;
                    end else begin
                        r_hdr_ready <= 1'b1;
                    end
                end
                HEADER: begin
                    r_hdr_ready <= 1'b0;
                    if (data_out_ready && w_ser_last) begin
                        r_state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (w_pay_fire && data_in_eop) begin
                        r_state     <= IDLE;
                        r_hdr_ready <= 1'b1;
                    end else begin
                        r_hdr_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_hdr_ready <= 1'b0;
                end
            endcase
        end
    end

    assign header_ready = r_hdr_ready;

    // Output mux: header beats from the serializer, then zero-latency
    // pass-through of the payload with its sop dropped.
    always_comb begin
        data_out_valid = 1'b0;
        data_out_data  = '0;
        data_out_sop   = 1'b0;
        data_out_eop   = 1'b0;
        data_in_ready  = 1'b0;
        case (r_state)
            HEADER: begin
                data_out_valid = 1'b1;
                data_out_data  = w_ser_data;
                data_out_sop   = w_ser_first;
            end
            PAYLOAD: begin
                data_out_valid = data_in_valid;
                data_out_data  = data_in_data;
                data_out_eop   = data_in_eop;
                data_in_ready  = data_out_ready;
            end
            default: begin
                data_out_valid = 1'b0;
            end
        endcase
    end

    // Header beats are generated locally, so their stability under
    // backpressure is this block's responsibility; payload stability is
    // inherited from the upstream source.
    a_header_hold : assert property (@(posedge clk) disable iff (rst)
        (r_state == HEADER && !data_out_ready) |=>
            (data_out_valid && $stable(data_out_data) && $stable(data_out_sop)));

    a_ready_only_idle : assert property (@(posedge clk)
        header_ready |-> (r_state == IDLE));

endmodule
`default_nettype wire

// File: tb/tb_header_inserter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module     : tb_header_inserter
//  Description: Self-checking bench for header_inserter (DATA_WIDTH=8,
//               HEADER_SIZE=16). Expected output beats are built from the
//               packet rules: two header bytes MSB first (sop on the first),
//               then the payload bytes with sop cleared and eop on the last.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_header_inserter;

    localparam int DW = 8;
    localparam int HS = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          data_in_valid = 1'b0;
    logic          data_in_ready;
    logic [DW-1:0] data_in_data = '0;
    logic          data_in_sop = 1'b0;
    logic          data_in_eop = 1'b0;
    logic [HS-1:0] header_data = '0;
    logic          header_valid = 1'b0;
    logic          header_ready;
    logic          data_out_valid;
    logic          data_out_ready = 1'b0;
    logic [DW-1:0] data_out_data;
    logic          data_out_sop;
    logic          data_out_eop;

    header_inserter #(.DATA_WIDTH(DW), .HEADER_SIZE(HS)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_in_data   (data_in_data),
        .data_in_sop    (data_in_sop),
        .data_in_eop    (data_in_eop),
        .header_data    (header_data),
        .header_valid   (header_valid),
        .header_ready   (header_ready),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .data_out_data  (data_out_data),
        .data_out_sop   (data_out_sop),
        .data_out_eop   (data_out_eop)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int timeouts = 0;
    int stall_viol = 0;
    int ready_mode = 0;   // 0: always ready, 1: toggle, 2: random

    // beat encoding: [9]=sop [8]=eop [7:0]=data
    logic [9:0]  obs_q[$];
    logic [9:0]  exp_q[$];
    logic        prev_stall = 1'b0;
    logic [10:0] prev_beat = '0;

    // downstream ready pattern
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       data_out_ready = 1'b1;
            1:       data_out_ready = ~data_out_ready;
            default: data_out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // output monitor: record accepted beats, watch hold-while-stalled
    always @(negedge clk) begin
        if (!rst && data_out_valid && data_out_ready)
            obs_q.push_back({data_out_sop, data_out_eop, data_out_data});
        if (prev_stall && !rst &&
            ({data_out_valid, data_out_sop, data_out_eop, data_out_data} !== prev_beat))
            stall_viol++;
        prev_stall = !rst && data_out_valid && !data_out_ready;
        prev_beat  = {data_out_valid, data_out_sop, data_out_eop, data_out_data};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // reference model: what one packet must look like on data_out
    task automatic add_exp(input logic [15:0] h, input logic [7:0] d [0:15], input int n);
        exp_q.push_back({1'b1, 1'b0, h[15:8]});
        exp_q.push_back({1'b0, 1'b0, h[7:0]});
        for (int i = 0; i < n; i++)
            exp_q.push_back({1'b0, (i == n - 1), d[i]});
    endtask

    task automatic compare_q(input string tag);
        chk($sformatf("%s count", tag), obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("%s beat%0d", tag, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    // all drivers are entered and left at posedge+1
    task automatic send_header(input logic [15:0] h);
        int   g;
        logic acc;
        g = 0;
        header_data  = h;
        header_valid = 1'b1;
        do begin
            @(negedge clk); acc = header_ready;
            @(posedge clk); #1; g++;
        end while (!acc && g < 500);
        if (!acc) timeouts++;
        header_valid = 1'b0;
    endtask

    task automatic send_payload(input int n, input logic [7:0] d [0:15],
                                input bit mid_sop, input bit gaps);
        int   g;
        logic acc;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                data_in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            data_in_valid = 1'b1;
            data_in_data  = d[i];
            data_in_sop   = (i == 0) || (mid_sop && i == 1);
            data_in_eop   = (i == n - 1);
            g = 0;
            do begin
                @(negedge clk); acc = data_in_ready;
                @(posedge clk); #1; g++;
            end while (!acc && g < 500);
            if (!acc) timeouts++;
        end
        data_in_valid = 1'b0;
        data_in_sop   = 1'b0;
        data_in_eop   = 1'b0;
    endtask

    logic [7:0]  d  [0:15];
    logic [7:0]  d2 [0:15];
    logic [15:0] h;
    int          n;
    int          k;
    int          g;
    logic        acc;
    bit          ms;

    initial begin
        for (int i = 0; i < 16; i++) begin
            d[i]  = 8'(i);
            d2[i] = 8'h00;
        end

        // ---- reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst header_ready", header_ready, 0);
        chk("rst out_valid", data_out_valid, 0);
        chk("rst out_sop", data_out_sop, 0);
        chk("rst out_eop", data_out_eop, 0);
        chk("rst out_data", data_out_data, 0);
        chk("rst in_ready", data_in_ready, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle header_ready", header_ready, 1);

        // ---- header ABCD, payload 0..9, always ready
        ready_mode = 0;
        add_exp(16'hABCD, d, 10);
        send_header(16'hABCD);
        send_payload(10, d, 0, 0);
        compare_q("basic");

        // ---- same with ready toggling every cycle
        ready_mode = 1;
        add_exp(16'hABCD, d, 10);
        fork
            send_header(16'hABCD);
            send_payload(10, d, 0, 0);
        join
        compare_q("toggle");

        // ---- payload offered 3 cycles before the header
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        data_in_valid = 1'b1;
        data_in_data  = d[0];
        data_in_sop   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("early in_ready", data_in_ready, 0);
            @(posedge clk); #1;
        end
        add_exp(16'hABCD, d, 10);
        fork
            send_header(16'hABCD);
            send_payload(10, d, 0, 0);
        join
        compare_q("early");

        // ---- back-to-back: 1-beat payload, next header already waiting
        d2[0] = 8'h55;
        add_exp(16'hABCD, d2, 1);
        for (int i = 0; i < 3; i++) d2[i] = 8'(8'hA0 + i);
        add_exp(16'h1234, d2, 3);
        d2[0] = 8'h55;
        fork
            begin
                send_header(16'hABCD);
                send_header(16'h1234);
            end
            begin
                send_payload(1, d2, 0, 0);
                d2[0] = 8'hA0;
                send_payload(3, d2, 0, 0);
            end
        join
        compare_q("b2b");

        // ---- randomized packets, random backpressure, gaps, stray sop
        for (int p = 0; p < 20; p++) begin
            h = 16'($urandom);
            n = $urandom_range(1, 8);
            for (int i = 0; i < 16; i++) d2[i] = 8'($urandom);
            ms = (n > 2) && ($urandom_range(0, 1) == 1);
            ready_mode = $urandom_range(0, 2);
            add_exp(h, d2, n);
            fork
                send_header(h);
                send_payload(n, d2, ms, 1);
            join
        end
        compare_q("rand");

        // ---- reset while payload beat 4 is on the bus
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        send_header(16'h0F0F);
        data_in_valid = 1'b1;
        data_in_data  = 8'd0;
        data_in_sop   = 1'b1;
        k = 0;
        g = 0;
        while (k < 4 && g < 200) begin
            @(negedge clk); acc = data_in_ready;
            @(posedge clk); #1; g++;
            if (acc) begin
                k++;
                data_in_data = 8'(k);
                data_in_sop  = 1'b0;
            end
        end
        chk("pre-rst beats", obs_q.size(), 6);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst out_valid", data_out_valid, 0);
        chk("midrst header_ready", header_ready, 0);
        data_in_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("postrst header_ready", header_ready, 1);
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 16; i++) d2[i] = 8'(8'h30 + i);
        add_exp(16'h5AA5, d2, 5);
        fork
            send_header(16'h5AA5);
            send_payload(5, d2, 0, 0);
        join
        compare_q("postrst");

        chk("timeouts", timeouts, 0);
        chk("stall hold", stall_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
